// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 (CPU MEM stage) has
// fixed priority, and a saturating starvation counter forces a port-1 grant.
module dm_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic [DATA_W/8-1:0]   m0_web,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_din,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_dout,
    input  logic                  m1_req,
    input  logic [DATA_W/8-1:0]   m1_web,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_din,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_dout,
    output logic                  DM_CS,
    output logic [DATA_W/8-1:0]   DM_WEB,
    output logic [ADDR_W-1:0]     DM_A,
    output logic [DATA_W-1:0]     DM_DI,
    input  logic [DATA_W-1:0]     DM_DO
);

    localparam int unsigned WEB_W = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    owner_t             r_rd_owner;
    owner_t             w_rd_owner_nxt;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic [CNT_W-1:0]   w_starve_cnt_nxt;
    logic               w_m0_gnt;
    logic               w_m1_gnt;
    logic               w_starved;

    // Port 1 wins only when port 0 is idle or port 1 has waited long enough.
    assign w_starved = (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign w_m0_gnt  = !rst && m0_req && (!m1_req || !w_starved);
    assign w_m1_gnt  = !rst && m1_req && (!m0_req || w_starved);

    assign m0_gnt = w_m0_gnt;
    assign m1_gnt = w_m1_gnt;

    always_comb begin
        DM_CS  = 1'b0;
        DM_WEB = {WEB_W{1'b1}};
        DM_A   = '0;
        DM_DI  = '0;
        if (w_m0_gnt) begin
            DM_CS  = 1'b1;
            DM_WEB = m0_web;
            DM_A   = m0_addr;
            DM_DI  = m0_din;
        end else if (w_m1_gnt) begin
            DM_CS  = 1'b1;
            DM_WEB = m1_web;
            DM_A   = m1_addr;
            DM_DI  = m1_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_owner   <= OWN_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_rd_owner   <= w_rd_owner_nxt;
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    // Next read owner and starvation count; writes and idle cycles clear the owner.
    always_comb begin
        w_rd_owner_nxt   = OWN_NONE;
        w_starve_cnt_nxt = '0;
        if (w_m0_gnt && (&m0_web)) begin
            w_rd_owner_nxt = OWN_M0;
        end else if (w_m1_gnt && (&m1_web)) begin
            w_rd_owner_nxt = OWN_M1;
        end
        if (m1_req && !w_m1_gnt) begin
            w_starve_cnt_nxt = w_starved ? r_starve_cnt : r_starve_cnt + CNT_W'(1);
        end
    end

    // A reset in the return cycle suppresses the pending read data.
    assign m0_rvalid = !rst && (r_rd_owner == OWN_M0);
    assign m1_rvalid = !rst && (r_rd_owner == OWN_M1);
    assign m0_dout   = m0_rvalid ? DM_DO : '0;
    assign m1_dout   = m1_rvalid ? DM_DO : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model.
module tb_dm_arbiter;

    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WEB_W      = DATA_W / 8;
    localparam int          STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m1_req;
    logic [WEB_W-1:0]  m0_web, m1_web;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_din, m1_din;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_dout, m1_dout;
    logic              DM_CS;
    logic [WEB_W-1:0]  DM_WEB;
    logic [ADDR_W-1:0] DM_A;
    logic [DATA_W-1:0] DM_DI, DM_DO;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int starve  = 0;   // consecutive denied port-1 cycles
    int last_rd = -1;  // port that issued a read last cycle, -1 = none
    bit last_g0 = 1'b0;
    bit last_g1 = 1'b0;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_web(m0_web), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_web(m1_web), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_dout(m1_dout),
        .DM_CS(DM_CS), .DM_WEB(DM_WEB), .DM_A(DM_A), .DM_DI(DM_DI), .DM_DO(DM_DO)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are set at the falling edge; check just after, then advance the model.
    task automatic run_cycle();
        bit g0, g1, rv0, rv1;
        logic [WEB_W-1:0]  e_web;
        logic [ADDR_W-1:0] e_a;
        logic [DATA_W-1:0] e_di;
        #1;
        g0 = !rst && m0_req && (!m1_req || starve < STARVE_MAX);
        g1 = !rst && m1_req && (!m0_req || starve >= STARVE_MAX);
        e_web = '1; e_a = '0; e_di = '0;
        if (g0) begin e_web = m0_web; e_a = m0_addr; e_di = m0_din; end
        if (g1) begin e_web = m1_web; e_a = m1_addr; e_di = m1_din; end
        check("m0_gnt", 64'(m0_gnt), 64'(g0));
        check("m1_gnt", 64'(m1_gnt), 64'(g1));
        check("DM_CS",  64'(DM_CS),  64'(g0 | g1));
        check("DM_WEB", 64'(DM_WEB), 64'(e_web));
        check("DM_A",   64'(DM_A),   64'(e_a));
        check("DM_DI",  64'(DM_DI),  64'(e_di));
        if (!rst) begin
            rv0 = (last_rd == 0);
            rv1 = (last_rd == 1);
            check("m0_rvalid", 64'(m0_rvalid), 64'(rv0));
            check("m1_rvalid", 64'(m1_rvalid), 64'(rv1));
            check("m0_dout", 64'(m0_dout), rv0 ? 64'(DM_DO) : 64'd0);
            check("m1_dout", 64'(m1_dout), rv1 ? 64'(DM_DO) : 64'd0);
        end
        if (rst) begin
            starve  = 0;
            last_rd = -1;
        end else begin
            if (m1_req && !g1) starve = (starve + 1 > STARVE_MAX) ? STARVE_MAX : starve + 1;
            else               starve = 0;
            if (g0 && m0_web == '1)      last_rd = 0;
            else if (g1 && m1_web == '1) last_rd = 1;
            else                         last_rd = -1;
        end
        last_g0 = g0;
        last_g1 = g1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_web = '1; m0_addr = '0; m0_din = '0;
        m1_req = 1'b0; m1_web = '1; m1_addr = '0; m1_din = '0;
        DM_DO  = $urandom;
    endtask

    task automatic new_req0();
        m0_req  = ($urandom_range(0, 3) != 0);
        m0_web  = ($urandom_range(0, 1) != 0) ? '1 : WEB_W'($urandom);
        m0_addr = ADDR_W'($urandom);
        m0_din  = $urandom;
    endtask

    task automatic new_req1();
        m1_req  = ($urandom_range(0, 2) != 0);
        m1_web  = ($urandom_range(0, 1) != 0) ? '1 : WEB_W'($urandom);
        m1_addr = ADDR_W'($urandom);
        m1_din  = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        // reset state, with requests present to prove grants are blocked
        run_cycle();
        m0_req = 1'b1; m1_req = 1'b1;
        run_cycle();
        rst = 1'b0;
        idle_inputs();
        run_cycle();

        // m0 read, data returned next cycle
        m0_req = 1'b1; m0_web = 4'hF; m0_addr = 14'h010;
        run_cycle();
        idle_inputs();
        DM_DO = 32'hDEADBEEF;
        #1;
        check("t1_m0_dout", 64'(m0_dout), 64'hDEADBEEF);
        run_cycle();

        // m1 byte write at top address
        m1_req = 1'b1; m1_web = 4'b1101; m1_addr = 14'h3FFF; m1_din = 32'h00AB0000;
        run_cycle();
        idle_inputs();
        run_cycle();

        // both request continuously: m0 x4, forced m1, m0 resumes
        m0_req = 1'b1; m0_web = 4'hF; m0_addr = 14'h100;
        m1_req = 1'b1; m1_web = 4'hF; m1_addr = 14'h200;
        for (int i = 0; i < 7; i++) begin
            DM_DO = $urandom;
            if (i == 4) begin
                #1;
                check("t3_forced_m1", 64'(m1_gnt), 64'd1);
            end
            run_cycle();
        end
        idle_inputs();
        run_cycle();

        // back-to-back reads m0 then m1
        m0_req = 1'b1; m0_web = 4'hF; m0_addr = 14'h001;
        run_cycle();
        idle_inputs();
        m1_req = 1'b1; m1_web = 4'hF; m1_addr = 14'h002; DM_DO = 32'h11111111;
        run_cycle();
        idle_inputs();
        DM_DO = 32'h22222222;
        run_cycle();
        run_cycle();

        // reset in the cycle after a granted read
        m0_req = 1'b1; m0_web = 4'hF; m0_addr = 14'h0AA;
        run_cycle();
        rst = 1'b1;
        DM_DO = 32'hCAFEF00D;
        run_cycle();
        rst = 1'b0;
        idle_inputs();
        run_cycle();

        // m1 denied 3 cycles, then alone -> granted at once
        m0_req = 1'b1; m0_web = 4'h0; m0_addr = 14'h050;
        m1_req = 1'b1; m1_web = 4'h0; m1_addr = 14'h060;
        for (int i = 0; i < 3; i++) run_cycle();
        m0_req = 1'b0;
        run_cycle();
        m0_req = 1'b1;
        run_cycle();
        idle_inputs();
        run_cycle();

        // random traffic obeying hold-until-grant
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!m0_req || last_g0) new_req0();
            if (!m1_req || last_g1) new_req1();
            DM_DO = $urandom;
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
